// File: rtl/kbd_scan_rx.sv
// Keyboard scan-code receiver: synchronises nibble strobes from the keyboard
// controller, assembles PS/2 set-2 bytes, decodes make/break/extended
// prefixes with shift tracking, translates makes to ASCII and queues the
// characters for the CPU behind a level int_req / int_ack handshake.
module kbd_scan_rx #(
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       kbd_enb_hi,
   input  logic       kbd_enb_lo,
   input  logic [3:0] kbd_data,
   input  logic       int_ack,
   output logic       int_req,
   output logic [7:0] kbd_ascii,
   output logic       overflow
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BREAK     = 2'd1,
      ST_EXT       = 2'd2,
      ST_EXT_BREAK = 2'd3
   } state_t;

   // Set-2 make code to 7-bit ASCII; bit 7 of the result flags a known code.
   function automatic logic [7:0] xlate_code(input logic [7:0] code, input logic shift);
      logic [6:0] lc;
      logic       is_letter;
      logic [7:0] res;
      lc        = 7'h00;
      is_letter = 1'b1;
      res       = 8'h00;
      case (code)
         8'h1C: lc = 7'h61;
         8'h32: lc = 7'h62;
         8'h21: lc = 7'h63;
         8'h23: lc = 7'h64;
         8'h24: lc = 7'h65;
         8'h2B: lc = 7'h66;
         8'h34: lc = 7'h67;
         8'h33: lc = 7'h68;
         8'h43: lc = 7'h69;
         8'h3B: lc = 7'h6A;
         8'h42: lc = 7'h6B;
         8'h4B: lc = 7'h6C;
         8'h3A: lc = 7'h6D;
         8'h31: lc = 7'h6E;
         8'h44: lc = 7'h6F;
         8'h4D: lc = 7'h70;
         8'h15: lc = 7'h71;
         8'h2D: lc = 7'h72;
         8'h1B: lc = 7'h73;
         8'h2C: lc = 7'h74;
         8'h3C: lc = 7'h75;
         8'h2A: lc = 7'h76;
         8'h1D: lc = 7'h77;
         8'h22: lc = 7'h78;
         8'h35: lc = 7'h79;
         8'h1A: lc = 7'h7A;
         default: is_letter = 1'b0;
      endcase
      if (is_letter) begin
         // Upper case sits exactly 0x20 below lower case.
         res = {1'b1, shift ? (lc - 7'h20) : lc};
      end else begin
         case (code)
            8'h45: res = 8'hB0;
            8'h16: res = 8'hB1;
            8'h1E: res = 8'hB2;
            8'h26: res = 8'hB3;
            8'h25: res = 8'hB4;
            8'h2E: res = 8'hB5;
            8'h36: res = 8'hB6;
            8'h3D: res = 8'hB7;
            8'h3E: res = 8'hB8;
            8'h46: res = 8'hB9;
            8'h29: res = 8'hA0;
            8'h5A: res = 8'h8D;
            8'h66: res = 8'h88;
            default: res = 8'h00;
         endcase
      end
      return res;
   endfunction

   // Synchroniser stages; the third flop of each strobe is the edge-detect history.
   logic       hi_s1_q, hi_s2_q, hi_s3_q;
   logic       lo_s1_q, lo_s2_q, lo_s3_q;
   logic       ack_s1_q, ack_s2_q, ack_s3_q;
   logic [3:0] data_s1_q, data_s2_q;

   logic       hi_rise, lo_rise, ack_rise;

   // Byte assembly
   logic [3:0] hi_q, hi_d;
   logic       hi_valid_q, hi_valid_d;
   logic       byte_valid;
   logic [7:0] byte_val;

   // Decoder
   state_t     state_q;
   logic       shift_q;
   logic       push_q;
   logic [6:0] push_chr_q;
   logic [7:0] xlate;
   logic       is_shift_code;

   // FIFO
   logic [6:0]       mem_q [FIFO_DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
   logic             empty, full, pop, push_ok, drop;
   logic             int_req_q, overflow_q;
   logic [7:0]       kbd_ascii_q;

   // Two-flop synchronisers plus one history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_s1_q   <= 1'b0;
         hi_s2_q   <= 1'b0;
         hi_s3_q   <= 1'b0;
         lo_s1_q   <= 1'b0;
         lo_s2_q   <= 1'b0;
         lo_s3_q   <= 1'b0;
         ack_s1_q  <= 1'b0;
         ack_s2_q  <= 1'b0;
         ack_s3_q  <= 1'b0;
         data_s1_q <= 4'h0;
         data_s2_q <= 4'h0;
      end else begin
         hi_s1_q   <= kbd_enb_hi;
         hi_s2_q   <= hi_s1_q;
         hi_s3_q   <= hi_s2_q;
         lo_s1_q   <= kbd_enb_lo;
         lo_s2_q   <= lo_s1_q;
         lo_s3_q   <= lo_s2_q;
         ack_s1_q  <= int_ack;
         ack_s2_q  <= ack_s1_q;
         ack_s3_q  <= ack_s2_q;
         data_s1_q <= kbd_data;
         data_s2_q <= data_s1_q;
      end
   end

   assign hi_rise  = hi_s2_q & ~hi_s3_q;
   assign lo_rise  = lo_s2_q & ~lo_s3_q;
   assign ack_rise = ack_s2_q & ~ack_s3_q;

   // Nibble pairing: a hi edge in the same cycle as a lo edge is applied first.
   always_comb begin
      hi_d       = hi_q;
      hi_valid_d = hi_valid_q;
      byte_valid = 1'b0;
      byte_val   = 8'h00;
      if (hi_rise) begin
         hi_d       = data_s2_q;
         hi_valid_d = 1'b1;
      end
      if (lo_rise && hi_valid_d) begin
         byte_valid = 1'b1;
         byte_val   = {hi_d, data_s2_q};
         hi_valid_d = 1'b0;
      end
   end

   // Pending high nibble register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q       <= 4'h0;
         hi_valid_q <= 1'b0;
      end else begin
         hi_q       <= hi_d;
         hi_valid_q <= hi_valid_d;
      end
   end

   assign xlate         = xlate_code(byte_val, shift_q);
   assign is_shift_code = (byte_val == 8'h12) || (byte_val == 8'h59);

   // Prefix decoder with shift tracking; emits a one-cycle push for each make.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= 1'b0;
         push_q     <= 1'b0;
         push_chr_q <= 7'h00;
      end else begin
         push_q <= 1'b0;
         if (byte_valid) begin
            case (state_q)
               ST_IDLE: begin
                  if (byte_val == 8'hF0) begin
                     state_q <= ST_BREAK;
                  end else if (byte_val == 8'hE0) begin
                     state_q <= ST_EXT;
                  end else if (is_shift_code) begin
                     shift_q <= 1'b1;
                  end else begin
                     push_q     <= xlate[7];
                     push_chr_q <= xlate[6:0];
                  end
               end
               ST_BREAK: begin
                  if (is_shift_code) begin
                     shift_q <= 1'b0;
                  end
                  state_q <= ST_IDLE;
               end
               ST_EXT: begin
                  state_q <= (byte_val == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign pop     = ack_rise & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok = push_q & (~full | pop);
   assign drop    = push_q & full & ~pop;

   // Character FIFO storage, pointers and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 7'h00;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_chr_q;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Registered CPU-facing view of the FIFO head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_req_q   <= 1'b0;
         kbd_ascii_q <= 8'h00;
      end else begin
         int_req_q   <= ~empty;
         kbd_ascii_q <= {1'b0, mem_q[rd_ptr_q[FIFO_AW-1:0]]};
      end
   end

   assign int_req   = int_req_q;
   assign kbd_ascii = kbd_ascii_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_kbd_scan_rx.sv
// Self-checking bench for kbd_scan_rx with a queue-based reference model.
module tb_kbd_scan_rx;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enb_hi, enb_lo, ack;
   logic [3:0] data;
   logic       int_req;
   logic [7:0] ascii;
   logic       ovf;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [7:0] mq[$];
   bit         m_ovf;
   bit         m_shift;
   int         m_pre;   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0

   logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   kbd_scan_rx #(.FIFO_DEPTH(DEPTH), .FIFO_AW(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .kbd_enb_hi (enb_hi),
      .kbd_enb_lo (enb_lo),
      .kbd_data   (data),
      .int_ack    (ack),
      .int_req    (int_req),
      .kbd_ascii  (ascii),
      .overflow   (ovf)
   );

   always #10 clk = ~clk;

   function automatic int ref_char(input logic [7:0] c, input bit sh);
      for (int i = 0; i < 26; i++) if (LET[i] == c) return sh ? (65 + i) : (97 + i);
      for (int i = 0; i < 10; i++) if (DIG[i] == c) return 48 + i;
      if (c == 8'h29) return 32;
      if (c == 8'h5A) return 13;
      if (c == 8'h66) return 8;
      return -1;
   endfunction

   task automatic model_push(input int ch);
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back(8'(ch));
   endtask

   task automatic model_byte(input logic [7:0] c);
      int ch;
      case (m_pre)
         0: begin
            if (c == 8'hF0) m_pre = 1;
            else if (c == 8'hE0) m_pre = 2;
            else if (c == 8'h12 || c == 8'h59) m_shift = 1'b1;
            else begin
               ch = ref_char(c, m_shift);
               if (ch >= 0) model_push(ch);
            end
         end
         1: begin
            if (c == 8'h12 || c == 8'h59) m_shift = 1'b0;
            m_pre = 0;
         end
         2: m_pre = (c == 8'hF0) ? 3 : 0;
         default: m_pre = 0;
      endcase
   endtask

   task automatic model_clear();
      mq.delete();
      m_ovf   = 1'b0;
      m_shift = 1'b0;
      m_pre   = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      enb_hi = 1'b0; enb_lo = 1'b0; ack = 1'b0; data = 4'h0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      model_clear();
   endtask

   task automatic send_nibbles(input logic [3:0] hi, input logic [3:0] lo);
      @(negedge clk) data = hi;
      @(negedge clk) enb_hi = 1'b1;
      repeat (3) @(negedge clk);
      enb_hi = 1'b0;
      @(negedge clk) data = lo;
      @(negedge clk) enb_lo = 1'b1;
      repeat (3) @(negedge clk);
      enb_lo = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_nibbles(b[7:4], b[3:0]);
      model_byte(b);
   endtask

   task automatic do_ack();
      @(negedge clk) ack = 1'b1;
      repeat (4) @(negedge clk);
      ack = 1'b0;
      repeat (4) @(negedge clk);
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++;
      if (int_req !== 1'b0 || ascii !== 8'h00 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_init: req=%b ascii=%h ovf=%b required 0/00/0", int_req, ascii, ovf);
      end
      send_byte(8'h1C);
      n_tests++;
      if (int_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_prefill_req: got %b required 1", int_req);
      end
      // Latch a high nibble 0x1, then reset asynchronously mid-byte.
      @(negedge clk) data = 4'h1;
      @(negedge clk) enb_hi = 1'b1;
      repeat (3) @(negedge clk);
      enb_hi = 1'b0;
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b0;
      #2;
      n_tests++;
      if (int_req !== 1'b0 || ascii !== 8'h00 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: req=%b ascii=%h ovf=%b required 0/00/0", int_req, ascii, ovf);
      end
      @(negedge clk) rst_n = 1'b1;
      model_clear();
      // A lone low nibble must not pair with the pre-reset high nibble.
      @(negedge clk) data = 4'hC;
      @(negedge clk) enb_lo = 1'b1;
      repeat (3) @(negedge clk);
      enb_lo = 1'b0;
      repeat (8) @(negedge clk);
      n_tests++;
      if (int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_lone_lo: req got %b required 0", int_req);
      end
   endtask

   task automatic test_single_make();
      int cnt;
      apply_reset();
      @(negedge clk) data = 4'h1;
      @(negedge clk) enb_hi = 1'b1;
      repeat (3) @(negedge clk);
      enb_hi = 1'b0;
      @(negedge clk) data = 4'hC;
      @(negedge clk) enb_lo = 1'b1;
      cnt = 0;
      while (int_req !== 1'b1 && cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      enb_lo = 1'b0;
      model_byte(8'h1C);
      repeat (4) @(negedge clk);
      n_tests++;
      if (cnt > 5) begin
         n_fail++;
         $display("FAIL make_latency: got %0d clocks required <=5", cnt);
      end
      n_tests++;
      if (ascii !== mq[0] || ascii !== 8'h61) begin
         n_fail++;
         $display("FAIL make_ascii: got %h required %h", ascii, mq[0]);
      end
      do_ack();
      n_tests++;
      if (int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL make_ack_req: got %b required 0", int_req);
      end
   endtask

   task automatic test_shift();
      logic [7:0] seq [5] = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C};
      apply_reset();
      foreach (seq[i]) send_byte(seq[i]);
      n_tests++;
      if (mq.size() != 2 || mq[0] !== 8'h41 || mq[1] !== 8'h61) begin
         n_fail++;
         $display("FAIL shift_model: size %0d required 2", mq.size());
      end
      while (mq.size() > 0) begin
         n_tests++;
         if (int_req !== 1'b1 || ascii !== mq[0]) begin
            n_fail++;
            $display("FAIL shift_head: req=%b ascii=%h required 1/%h", int_req, ascii, mq[0]);
         end
         do_ack();
      end
      n_tests++;
      if (int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL shift_drained: req got %b required 0", int_req);
      end
   endtask

   task automatic test_ignored();
      logic [7:0] seq [8] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1C, 8'h77};
      apply_reset();
      foreach (seq[i]) send_byte(seq[i]);
      n_tests++;
      if (int_req !== 1'b0 || mq.size() != 0) begin
         n_fail++;
         $display("FAIL ignored_codes: req got %b required 0", int_req);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      repeat (9) send_byte(8'h16);
      n_tests++;
      if (ovf !== 1'b1 || int_req !== 1'b1 || ascii !== 8'h31) begin
         n_fail++;
         $display("FAIL ovf_set: ovf=%b req=%b ascii=%h required 1/1/31", ovf, int_req, ascii);
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (int_req !== 1'b1 || ascii !== 8'h31) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: req=%b ascii=%h required 1/31", i, int_req, ascii);
         end
         do_ack();
      end
      n_tests++;
      if (int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_empty: req got %b required 0", int_req);
      end
      do_ack();
      n_tests++;
      if (int_req !== 1'b0 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_extra_ack: req=%b ovf=%b required 0/1", int_req, ovf);
      end
   endtask

   task automatic test_simul_push_pop();
      logic [7:0] fill [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
      logic [7:0] code;
      apply_reset();
      foreach (fill[i]) send_byte(fill[i]);
      for (int k = 0; k < 11; k++) begin
         code = (k == 0) ? 8'h45 : DIG[$urandom_range(0, 9)];
         @(negedge clk) data = code[7:4];
         @(negedge clk) enb_hi = 1'b1;
         repeat (3) @(negedge clk);
         enb_hi = 1'b0;
         @(negedge clk) data = code[3:0];
         // Ack lags the low strobe by one clock so its edge meets the push.
         @(negedge clk) enb_lo = 1'b1;
         @(negedge clk) ack = 1'b1;
         repeat (3) @(negedge clk);
         enb_lo = 1'b0;
         ack = 1'b0;
         repeat (5) @(negedge clk);
         void'(mq.pop_front());
         model_byte(code);
         n_tests++;
         if (ovf !== 1'b0 || int_req !== 1'b1 || ascii !== mq[0]) begin
            n_fail++;
            $display("FAIL simul_%0d: ovf=%b req=%b ascii=%h required 0/1/%h", k, ovf, int_req, ascii, mq[0]);
         end
      end
      while (mq.size() > 0) begin
         n_tests++;
         if (int_req !== 1'b1 || ascii !== mq[0]) begin
            n_fail++;
            $display("FAIL simul_order: req=%b ascii=%h required 1/%h", int_req, ascii, mq[0]);
         end
         do_ack();
      end
      n_tests++;
      if (int_req !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_end: req=%b ovf=%b required 0/0", int_req, ovf);
      end
   endtask

   task automatic test_random();
      logic [7:0] code;
      int sel;
      apply_reset();
      for (int it = 0; it < 160; it++) begin
         if ($urandom_range(0, 9) < 7) begin
            sel = $urandom_range(0, 9);
            case (sel)
               0, 1, 2, 3: code = LET[$urandom_range(0, 25)];
               4: code = DIG[$urandom_range(0, 9)];
               5: code = ($urandom_range(0, 2) == 0) ? 8'h29 : (($urandom_range(0, 1) == 0) ? 8'h5A : 8'h66);
               6: code = 8'hF0;
               7: code = 8'hE0;
               8: code = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
               default: code = 8'($urandom());
            endcase
            send_byte(code);
         end else begin
            n_tests++;
            if (int_req !== (mq.size() != 0) || (mq.size() != 0 && ascii !== mq[0])) begin
               n_fail++;
               $display("FAIL rand_head_%0d: req=%b ascii=%h required %b/%h", it, int_req, ascii,
                        mq.size() != 0, (mq.size() != 0) ? mq[0] : 8'h00);
            end
            do_ack();
         end
      end
      n_tests++;
      if (ovf !== m_ovf) begin
         n_fail++;
         $display("FAIL rand_ovf: got %b required %b", ovf, m_ovf);
      end
      while (mq.size() > 0) begin
         n_tests++;
         if (int_req !== 1'b1 || ascii !== mq[0]) begin
            n_fail++;
            $display("FAIL rand_drain: req=%b ascii=%h required 1/%h", int_req, ascii, mq[0]);
         end
         do_ack();
      end
      n_tests++;
      if (int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rand_end: req got %b required 0", int_req);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      enb_hi = 1'b0;
      enb_lo = 1'b0;
      ack    = 1'b0;
      data   = 4'h0;
      model_clear();
      test_reset();
      test_single_make();
      test_shift();
      test_ignored();
      test_overflow();
      test_simul_push_pop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
